reg_write_port: RTL and testbench
=================================

// Module: reg_write_port
// PURPOSE
//  Write side of the 16 x 16-bit register file: accepts write requests over a
//  valid/ready handshake, buffers them in a small FIFO, and commits them in order
//  into regQ0..regQ15, which feed the registered 16:1 read mux. Also runs a
//  sequenced clear-all that zeroes the file one register per cycle.
// PARAMETERS
//  DEPTH   2   request FIFO entries (power of 2, >= 2)
// PORTS
//  wclk          in   1    write clock; all state updates on posedge
//  clrn          in   1    asynchronous active-low reset
//  wr_valid      in   1    write request present
//  wr_ready      out  1    FIFO can accept (= !full)
//  wr_addr       in   4    target register index
//  wr_be         in   2    byte enables: [1]=bits 15:8, [0]=bits 7:0
//  wr_data       in   16   write data
//  clr_req       in   1    start clear-all sweep (level-sampled)
//  clr_busy      out  1    sweep in progress
//  clr_done      out  1    one-cycle pulse when sweep completes
//  fifo_level    out  log2(DEPTH)+1  entries currently buffered
//  regQ0..regQ15 out  16 each  register contents, to read mux
// BEHAVIOUR
//  Reset (clrn=0, async): regQ0..15=0, FIFO empty, fifo_level=0, wr_ready=1,
//   clr_busy=0, clr_done=0, sweep counter=0, FSM=IDLE.
//  Handshake: push {addr,be,data} on posedge when wr_valid&&wr_ready.
//   wr_ready = (fifo_level!=DEPTH), from registered state only; no push when full
//   even if a pop occurs the same edge. Inputs may change freely when !wr_valid.
//  FSM states IDLE, CLEAR.
//   IDLE: if clr_req=1 -> CLEAR (counter=0), no pop this edge (clear has priority).
//         else if FIFO non-empty: pop head, commit to regQ[addr] with byte enables.
//   CLEAR: each edge zero regQ[counter], counter++; on counter=15 edge -> IDLE,
//         clr_done=1 for the next cycle. clr_busy=1 throughout CLEAR (16 cycles).
//         FIFO keeps accepting (until full) but does not drain; clr_req ignored.
//  Commit: only enabled bytes updated; be=2'b00 pops with no register change.
//  Latency: request pushed into empty FIFO at edge N commits at edge N+1;
//   regQ shows new value after N+1 (read mux registers it again: N+2 at its output).
//  Ordering: strict FIFO; repeated writes to same addr land in acceptance order.
//  Simultaneous push+pop (not full): both occur, fifo_level unchanged.
//  Pointer wrap: read/write pointers wrap modulo DEPTH; level is the extra-bit diff.
//  Reset mid-sweep or mid-queue: everything returns to reset values immediately;
//   buffered requests are discarded.
//  No combinational path from inputs to any output.
// TESTING
//  1 Reset, then write addr=3 be=11 data=16'hA5C3 -> regQ3=A5C3 one edge after
//    accept; all other regQ stay 0.
//  2 be=10 data=16'h1234 to addr 3 (holding A5C3) -> regQ3=12C3; be=00 -> unchanged,
//    fifo_level returns to 0.
//  3 Hold clr_req=1 with DEPTH=2 and stream writes -> after 2 accepts wr_ready=0;
//    16 cycles later clr_done pulses, regQ0..15=0, then both queued writes commit.
//  4 Back-to-back writes addr 0..15 data=addr*16'h1111 with wr_valid held 1 ->
//    one accept per cycle, regQk=k*1111 in order, fifo_level never exceeds 1.
//  5 Two writes to addr 7 (16'h0001 then 16'h0002) queued together -> regQ7=0002.
//  6 Drop clrn at sweep step 8 with 2 queued writes -> all outputs at reset values,
//    no queued write commits after clrn rises.

Source files
------------

// File: rtl/reg_write_port_if.sv
// Write-request bus for the register-file write port.
//   wr_valid  request present (master -> slave)
//   wr_ready  slave can accept this cycle (slave -> master)
//   wr_addr   target register index
//   wr_be     byte enables: [1] = bits 15:8, [0] = bits 7:0
//   wr_data   write data
interface reg_write_port_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_be, output wr_data,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_be, input  wr_data,
                  output wr_ready);
endinterface

// File: rtl/reg_write_port.sv
// Write side of the 16 x 16-bit register file. Requests arrive over a
// valid/ready bus, are buffered in a DEPTH-entry FIFO and committed in order
// with byte enables. A clear-all sweep zeroes one register per cycle.
// Ports:
//   wclk           write clock
//   clrn           asynchronous active-low reset
//   wr             write-request bus (slave side)
//   clr_req        start clear-all sweep (level-sampled in IDLE)
//   clr_busy       sweep in progress
//   clr_done       one-cycle pulse after the last register is cleared
//   fifo_level     entries currently buffered
//   regQ0..regQ15  register contents, to the read mux
//
// state | meaning
// IDLE  | drain FIFO one entry per cycle; clr_req starts a sweep
// CLEAR | zero regQ[cnt] each cycle for 16 cycles; FIFO fills but never drains
module reg_write_port #(
  parameter int DEPTH = 2
) (
  input  logic                   wclk,
  input  logic                   clrn,
  reg_write_port_if.slave        wr,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            regQ0,
  output logic [15:0]            regQ1,
  output logic [15:0]            regQ2,
  output logic [15:0]            regQ3,
  output logic [15:0]            regQ4,
  output logic [15:0]            regQ5,
  output logic [15:0]            regQ6,
  output logic [15:0]            regQ7,
  output logic [15:0]            regQ8,
  output logic [15:0]            regQ9,
  output logic [15:0]            regQ10,
  output logic [15:0]            regQ11,
  output logic [15:0]            regQ12,
  output logic [15:0]            regQ13,
  output logic [15:0]            regQ14,
  output logic [15:0]            regQ15
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic        next_done;
  logic        pop, clr_we, push, fifo_empty;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr, rd_ptr;
  logic [3:0]  fifo_addr [DEPTH];
  logic [1:0]  fifo_be   [DEPTH];
  logic [15:0] fifo_data [DEPTH];
  logic [3:0]  head_addr;
  logic [1:0]  head_be;
  logic [15:0] head_data;

  logic [15:0] regs [16];

  assign fifo_level  = wr_ptr - rd_ptr;
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign wr.wr_ready = (fifo_level != FULL_LVL);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign head_addr   = fifo_addr[rd_ptr[AW-1:0]];
  assign head_be     = fifo_be[rd_ptr[AW-1:0]];
  assign head_data   = fifo_data[rd_ptr[AW-1:0]];
  assign clr_busy    = (state == CLEAR);

  always_ff @(posedge wclk) begin
    if (push) begin
      fifo_addr[wr_ptr[AW-1:0]] <= wr.wr_addr;
      fifo_be[wr_ptr[AW-1:0]]   <= wr.wr_be;
      fifo_data[wr_ptr[AW-1:0]] <= wr.wr_data;
    end
  end

  always_ff @(posedge wclk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge wclk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      clr_done <= next_done;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_done  = 1'b0;
    pop        = 1'b0;
    clr_we     = 1'b0;
    case (state)
      IDLE: begin
        // A clear request wins over draining on the same edge.
        if (clr_req) begin
          next_state = CLEAR;
          next_cnt   = '0;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      CLEAR: begin
        clr_we   = 1'b1;
        next_cnt = cnt + 4'd1;
        if (cnt == 4'd15) begin
          next_state = IDLE;
          next_done  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (clr_we) begin
      regs[cnt] <= '0;
    end else if (pop) begin
      if (head_be[0]) regs[head_addr][7:0]  <= head_data[7:0];
      if (head_be[1]) regs[head_addr][15:8] <= head_data[15:8];
    end
  end

  assign regQ0  = regs[0];
  assign regQ1  = regs[1];
  assign regQ2  = regs[2];
  assign regQ3  = regs[3];
  assign regQ4  = regs[4];
  assign regQ5  = regs[5];
  assign regQ6  = regs[6];
  assign regQ7  = regs[7];
  assign regQ8  = regs[8];
  assign regQ9  = regs[9];
  assign regQ10 = regs[10];
  assign regQ11 = regs[11];
  assign regQ12 = regs[12];
  assign regQ13 = regs[13];
  assign regQ14 = regs[14];
  assign regQ15 = regs[15];
endmodule

// File: tb/tb_reg_write_port.sv
// Bench for reg_write_port: directed scenarios plus random traffic, with a
// scoreboard monitor holding a reference register file.
module tb_reg_write_port;
  localparam int DEPTH = 2;

  logic wclk = 1'b0;
  logic clrn = 1'b0;
  always #5 wclk = ~wclk;

  reg_write_port_if bus();
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;
  logic [1:0]  fifo_level;
  logic [15:0] q [16];

  reg_write_port #(.DEPTH(DEPTH)) dut (
    .wclk(wclk), .clrn(clrn), .wr(bus),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .fifo_level(fifo_level),
    .regQ0(q[0]),   .regQ1(q[1]),   .regQ2(q[2]),   .regQ3(q[3]),
    .regQ4(q[4]),   .regQ5(q[5]),   .regQ6(q[6]),   .regQ7(q[7]),
    .regQ8(q[8]),   .regQ9(q[9]),   .regQ10(q[10]), .regQ11(q[11]),
    .regQ12(q[12]), .regQ13(q[13]), .regQ14(q[14]), .regQ15(q[15])
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack_q();
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = q[i];
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  typedef struct packed {
    logic [3:0]  a;
    logic [1:0]  be;
    logic [15:0] d;
  } req_t;

  req_t        sb[$];
  logic [15:0] model [16];
  int          lvl_prev, busy_cnt, pops, exp_pops, max_lvl;
  bit          acc_prev, req_prev, busy_prev;
  req_t        acc_item, cur;
  logic [255:0] exp_regs;

  always @(negedge wclk) begin
    if (!clrn) begin
      check("rst_regs", pack_q(), '0);
      check("rst_level", 256'(fifo_level), 256'(0));
      check("rst_ready", 256'(bus.wr_ready), 256'(1));
      check("rst_busy", 256'(clr_busy), 256'(0));
      check("rst_done", 256'(clr_done), 256'(0));
      sb.delete();
      for (int i = 0; i < 16; i++) model[i] = '0;
      lvl_prev = 0; acc_prev = 0; req_prev = 0; busy_prev = 0; busy_cnt = 0;
    end else begin
      if (acc_prev) sb.push_back(acc_item);
      pops = lvl_prev + int'(acc_prev) - int'(fifo_level);
      exp_pops = (busy_prev || req_prev || lvl_prev == 0) ? 0 : 1;
      check("pop_count", 256'(pops), 256'(exp_pops));
      if (pops == 1 && sb.size() > 0) begin
        cur = sb.pop_front();
        if (cur.be[0]) model[cur.a][7:0]  = cur.d[7:0];
        if (cur.be[1]) model[cur.a][15:8] = cur.d[15:8];
      end
      check("ready", 256'(bus.wr_ready), 256'(int'(fifo_level) != DEPTH));
      if (!busy_prev) check("busy_start", 256'(clr_busy), 256'(req_prev));
      check("clr_done", 256'(clr_done), 256'(busy_prev && !clr_busy));
      if (clr_busy) begin
        busy_cnt++;
        for (int i = 0; i < 16; i++)
          exp_regs[i*16 +: 16] = (i < busy_cnt - 1) ? 16'h0 : model[i];
        check("sweep_regs", pack_q(), exp_regs);
        check("sweep_len_max", 256'(busy_cnt <= 16), 256'(1));
      end else begin
        if (busy_prev) begin
          check("sweep_len", 256'(busy_cnt), 256'(16));
          for (int i = 0; i < 16; i++) model[i] = '0;
          busy_cnt = 0;
        end
        for (int i = 0; i < 16; i++) exp_regs[i*16 +: 16] = model[i];
        check("regs", pack_q(), exp_regs);
      end
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      acc_prev  = bus.wr_valid && bus.wr_ready;
      acc_item  = '{a: bus.wr_addr, be: bus.wr_be, d: bus.wr_data};
      req_prev  = clr_req;
      busy_prev = clr_busy;
      lvl_prev  = int'(fifo_level);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Presents one request and returns just after the edge that accepts it.
  task automatic send(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d,
                      output int waits);
    bit ok;
    ok = 0;
    waits = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_be    = be;
    bus.wr_data  = d;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge wclk);
      ok = bus.wr_ready;
      waits++;
      tick();
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge wclk);
      ok = (fifo_level == 0) && !clr_busy;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got level %0d busy %0d expected idle", fifo_level, clr_busy);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100us");
    $fatal(1);
  end

  int           w, wsum;
  bit           ok;
  logic [255:0] e;

  initial begin
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_be = 0; bus.wr_data = 0;
    clr_req = 0;
    clrn = 0;
    tick(); tick(); tick();
    clrn = 1;

    // Full write, then exact commit latency.
    send(4'd3, 2'b11, 16'hA5C3, w);
    bus.wr_valid = 0;
    @(negedge wclk);
    check("t1_before_commit", 256'(q[3]), 256'(0));
    @(negedge wclk);
    e = '0; e[3*16 +: 16] = 16'hA5C3;
    check("t1_regs", pack_q(), e);
    tick();

    // Byte enables.
    send(4'd3, 2'b10, 16'h1234, w);
    bus.wr_valid = 0;
    wait_drain();
    check("t2_upper_byte", 256'(q[3]), 256'(16'h12C3));
    send(4'd3, 2'b00, 16'hFFFF, w);
    bus.wr_valid = 0;
    wait_drain();
    check("t2_be_none", 256'(q[3]), 256'(16'h12C3));
    check("t2_level", 256'(fifo_level), 256'(0));

    // Back-to-back stream with valid held.
    max_lvl = 0;
    wsum = 0;
    for (int k = 0; k < 16; k++) begin
      send(4'(k), 2'b11, 16'(k * 16'h1111), w);
      wsum += w;
    end
    bus.wr_valid = 0;
    wait_drain();
    check("t4_one_per_cycle", 256'(wsum), 256'(16));
    check("t4_max_level", 256'(max_lvl), 256'(1));
    for (int k = 0; k < 16; k++) e[k*16 +: 16] = 16'(k * 16'h1111);
    check("t4_regs", pack_q(), e);

    // Clear sweep with writes queued behind it, then a second clear that
    // must win over draining on its first edge.
    clr_req = 1;
    tick();
    clr_req = 0;
    send(4'd7, 2'b11, 16'h0001, w);
    send(4'd7, 2'b11, 16'h0002, w);
    bus.wr_valid = 1; bus.wr_addr = 4'd9; bus.wr_be = 2'b11; bus.wr_data = 16'hBEEF;
    @(negedge wclk);
    check("t3_full_ready", 256'(bus.wr_ready), 256'(0));
    check("t3_full_level", 256'(fifo_level), 256'(2));
    ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      tick();
      ok = clr_done;
    end
    check("t3_done_seen", 256'(ok), 256'(1));
    check("t3_cleared", pack_q(), '0);
    clr_req = 1;
    tick();
    clr_req = 0;
    @(negedge wclk);
    check("t3_prio_busy", 256'(clr_busy), 256'(1));
    check("t3_prio_level", 256'(fifo_level), 256'(2));
    send(4'd9, 2'b11, 16'hBEEF, w);
    bus.wr_valid = 0;
    wait_drain();
    e = '0; e[7*16 +: 16] = 16'h0002; e[9*16 +: 16] = 16'hBEEF;
    check("t5_order", pack_q(), e);

    // Reset in the middle of a sweep with writes queued.
    clr_req = 1;
    tick();
    clr_req = 0;
    send(4'd1, 2'b11, 16'h1111, w);
    send(4'd2, 2'b11, 16'h2222, w);
    bus.wr_valid = 0;
    for (int n = 0; n < 6; n++) tick();
    clrn = 0;
    @(negedge wclk);
    check("t6_rst_level", 256'(fifo_level), 256'(0));
    check("t6_rst_busy", 256'(clr_busy), 256'(0));
    tick(); tick();
    clrn = 1;
    for (int n = 0; n < 5; n++) @(negedge wclk);
    check("t6_no_commit", pack_q(), '0);
    check("t6_level", 256'(fifo_level), 256'(0));
    tick();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bus.wr_valid = ($urandom_range(0, 1) == 1);
      bus.wr_addr  = 4'($urandom_range(0, 15));
      bus.wr_be    = 2'($urandom_range(0, 3));
      bus.wr_data  = 16'($urandom);
      clr_req      = ($urandom_range(0, 39) == 0);
      tick();
    end
    bus.wr_valid = 0;
    clr_req = 0;
    wait_drain();
    check("final_level", 256'(fifo_level), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
